mem_unit: RTL
=============

Name: mem_unit

Overview:
- Responder end of the unit interface for the memory unit: accepts one memory request (control, address, store data) from the thread's unit port and returns read data plus a one-cycle ready pulse.
- Bridges to a word-wide request/acknowledge memory bus.
- Handles byte/half/word lanes and splits misaligned accesses that cross a word boundary into two bus transactions.
- Sits between the top-level unit mux and the memory/peripheral interconnect.

Parameters:
TIMEOUT, 256, bus cycles to wait for bus_ack per transaction before aborting with err.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
sel  in  1  unit mux has selected the memory unit; request fields are valid.
ctrl  in  32  memory control word. ctrl[1:0] is the size: 00 byte, 01 half, 10 word, 11 illegal. ctrl[2] is the write bit. Other bits are ignored.
addr  in  32  byte address.
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
dout  out  32  load data, right-aligned and zero-extended. Undefined bits are 0.
ready  out  1  one-cycle completion pulse.
err  out  1  valid with ready: illegal size or bus timeout.
bus_req  out  1  bus request, held until bus_ack.
bus_we  out  1  write strobe.
bus_addr  out  32  word address, bits [1:0] always 0.
bus_be  out  4  byte-lane enables.
bus_wdata  out  32  lane-aligned write data.
bus_ack  in  1  bus completion. May assert in the same cycle as bus_req.
bus_rdata  in  32  read data, valid when bus_ack=1.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. dout, ready, err, bus_req, bus_we, bus_be, bus_addr, bus_wdata are all 0. The timeout counter is 0. Reset during any state drops bus_req immediately.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE, entered with sel=1:
  - Latch ctrl, addr, wdata.
  - Compute off=addr[1:0] and mask = 0x1/0x3/0xF for byte/half/word.
  - Set split = (half and off==3) or (word and off!=0).
  - Illegal size: go to DONE with err=1, dout=0, and no bus access.
  - Otherwise go to ACC0.
  - With sel=0, stay in IDLE.
- ACC0:
  - Drive bus_req=1, bus_addr={addr[31:2],2'b00}, bus_be=(mask<<off)[3:0], bus_we=write, bus_wdata=wdata<<(8*off).
  - On bus_ack: capture bus_rdata as low word, then go to ACC1 if split, else DONE.
- ACC1:
  - Drive bus_addr=({addr[31:2],2'b00}+4) mod 2^32, so 0xFFFFFFFC wraps to 0.
  - Drive bus_be=(mask<<off)[7:4] and bus_wdata=wdata>>(32-8*off).
  - On bus_ack: capture as high word, then go to DONE.
- Bus outputs are registered. All bus outputs are 0 whenever bus_req=0.
- Timeout: the counter is cleared on entering ACC0/ACC1 and increments each cycle without ack. When it reaches TIMEOUT-1 with no ack, drop bus_req, go to DONE with err=1, dout=0.
- Read data: dout = ({high,low} >> 8*off)[31:0] & zero-extended mask. high=0 when not split. Writes return dout=0.
- DONE:
  - ready=1 and err is valid for exactly one cycle; dout is valid in the same cycle.
  - dout holds until the next request is latched.
  - Next state is IDLE.
- Request fields are sampled only in IDLE. Changes to sel/ctrl/addr/wdata during ACC0/ACC1/DONE are ignored, and a request in flight completes even if sel drops.
- A new request can be latched in the cycle after DONE. The thread holds sel high until it sees ready, so the first IDLE cycle after DONE re-latches only when the next request is already presented.
- Latency, sel to ready:
  - Aligned access with same-cycle ack: 3 cycles.
  - Split access: 4 + total ack wait cycles.
  - Illegal size: 2 cycles.
- ready is 0 in all states except DONE. The top-level mux, not this block, supplies ready when the unit is not selected.

Test Plan:
- Aligned word read: ctrl=word, addr=0x100, bus_rdata=0xDEADBEEF with immediate ack. Expect bus_addr=0x100, be=0xF, ready 3 cycles after sel, dout=0xDEADBEEF, err=0.
- Byte store: addr=0x203, wdata=0x000000A5. Expect one transaction: bus_addr=0x200, be=0x8, bus_wdata=0xA5000000, ready pulse, dout=0.
- Split half read: addr=0x1FF. Memory word 0x1FC=0x11223344, word 0x200=0x55667788. Expect two transactions with be=0x8 then be=0x1, dout=0x00008811.
- Split word write with wrap: addr=0xFFFFFFFE, wdata=0xAABBCCDD. Expect bus_addr 0xFFFFFFFC be=0xC wdata=0xCCDD0000, then bus_addr 0x00000000 be=0x3 wdata=0x0000AABB.
- Timeout and illegal size: with bus_ack held 0 and TIMEOUT=8, expect bus_req to drop after 8 cycles, then ready=1, err=1, dout=0. Size=11 gives ready in 2 cycles, err=1, bus_req never asserted.
- Reset mid-access: rst=0 while in ACC1 awaiting ack. Expect bus_req=0 immediately and all outputs 0. After release, a fresh aligned read completes normally.

Source files
------------

// File: rtl/mem_unit_if.sv
// Unit-port and memory-bus signal bundle for the memory unit.
// Latency: none, wiring only.
// Backpressure: request side is held by sel until ready; bus side is req/ack.
interface mem_unit_if;
    // unit port
    logic        sel;
    logic [31:0] ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        ready;
    logic        err;
    // memory bus
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    // the memory unit responds to requests and masters the bus
    modport slave (
        input  sel, ctrl, addr, wdata, bus_ack, bus_rdata,
        output dout, ready, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    // the environment: thread/unit mux plus memory interconnect
    modport master (
        output sel, ctrl, addr, wdata, bus_ack, bus_rdata,
        input  dout, ready, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/mem_unit.sv
// Memory unit: byte/half/word loads and stores, misaligned accesses split in two bus words.
// Latency: sel to ready 3 cycles aligned, 4 + ack waits split, 2 for illegal size.
// Backpressure: each bus beat holds bus_req until bus_ack, aborted with err after TIMEOUT cycles.
module mem_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    mem_unit_if.slave  io
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t state, state_n;

    // latched request
    logic [1:0]  size_q, size_n;
    logic        we_q, we_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        split_q, split_n;
    logic [31:0] low_q, low_n;
    logic [CW-1:0] cnt_q, cnt_n;

    // registered outputs
    logic [31:0] dout_q, dout_n;
    logic        ready_q, ready_n;
    logic        err_q, err_n;
    logic        req_q, req_n;
    logic        bwe_q, bwe_n;
    logic [31:0] baddr_q, baddr_n;
    logic [3:0]  be_q, be_n;
    logic [31:0] bwdata_q, bwdata_n;

    // lane helpers
    logic [7:0]  be8_in, be8_lat;
    logic [63:0] data_lat;
    logic [31:0] data_in;
    logic [31:0] base_lat;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'h1;
            2'b01:   size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
    endfunction

    function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
        is_split = ((size == 2'b01) && (off == 2'd3)) || ((size == 2'b10) && (off != 2'd0));
    endfunction

    // Shift the two-word window down to the access offset and keep only the accessed lanes.
    function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] sh;
        logic [31:0] m;
        sh = {hi, lo} >> {off, 3'b000};
        case (size)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        extract = sh[31:0] & m;
    endfunction

    logic unused_ok;
    assign unused_ok = &{1'b0, io.ctrl[31:3], be8_in[7:4]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next state, next latched fields and next registered outputs
    always_comb begin
        state_n  = state;
        size_n   = size_q;
        we_n     = we_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        split_n  = split_q;
        low_n    = low_q;
        cnt_n    = cnt_q;
        dout_n   = dout_q;
        ready_n  = 1'b0;
        err_n    = 1'b0;
        req_n    = 1'b0;
        bwe_n    = 1'b0;
        baddr_n  = 32'h0;
        be_n     = 4'h0;
        bwdata_n = 32'h0;

        be8_in   = {4'h0, size_mask(io.ctrl[1:0])} << io.addr[1:0];
        data_in  = io.wdata << {io.addr[1:0], 3'b000};
        be8_lat  = {4'h0, size_mask(size_q)} << addr_q[1:0];
        data_lat = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
        base_lat = {addr_q[31:2], 2'b00};

        case (state)
            IDLE: begin
                if (io.sel) begin
                    size_n  = io.ctrl[1:0];
                    we_n    = io.ctrl[2];
                    addr_n  = io.addr;
                    wdata_n = io.wdata;
                    split_n = is_split(io.ctrl[1:0], io.addr[1:0]);
                    low_n   = 32'h0;
                    dout_n  = 32'h0;
                    if (io.ctrl[1:0] == 2'b11) begin
                        state_n = DONE;
                        ready_n = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        state_n  = ACC0;
                        cnt_n    = '0;
                        req_n    = 1'b1;
                        bwe_n    = io.ctrl[2];
                        baddr_n  = {io.addr[31:2], 2'b00};
                        be_n     = be8_in[3:0];
                        bwdata_n = data_in;
                    end
                end
            end
            ACC0, ACC1: begin
                if (io.bus_ack) begin
                    if (state == ACC0 && split_q) begin
                        low_n    = io.bus_rdata;
                        state_n  = ACC1;
                        cnt_n    = '0;
                        req_n    = 1'b1;
                        bwe_n    = we_q;
                        baddr_n  = base_lat + 32'd4;
                        be_n     = be8_lat[7:4];
                        bwdata_n = data_lat[63:32];
                    end else begin
                        state_n = DONE;
                        ready_n = 1'b1;
                        if (we_q)
                            dout_n = 32'h0;
                        else if (state == ACC0)
                            dout_n = extract(size_q, addr_q[1:0], 32'h0, io.bus_rdata);
                        else
                            dout_n = extract(size_q, addr_q[1:0], io.bus_rdata, low_q);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_n = DONE;
                    ready_n = 1'b1;
                    err_n   = 1'b1;
                    dout_n  = 32'h0;
                end else begin
                    cnt_n    = cnt_q + 1'b1;
                    req_n    = req_q;
                    bwe_n    = bwe_q;
                    baddr_n  = baddr_q;
                    be_n     = be_q;
                    bwdata_n = bwdata_q;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Latched request fields and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_q   <= 2'b00;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            split_q  <= 1'b0;
            low_q    <= 32'h0;
            cnt_q    <= '0;
            dout_q   <= 32'h0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= 32'h0;
            be_q     <= 4'h0;
            bwdata_q <= 32'h0;
        end else begin
            size_q   <= size_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            split_q  <= split_n;
            low_q    <= low_n;
            cnt_q    <= cnt_n;
            dout_q   <= dout_n;
            ready_q  <= ready_n;
            err_q    <= err_n;
            req_q    <= req_n;
            bwe_q    <= bwe_n;
            baddr_q  <= baddr_n;
            be_q     <= be_n;
            bwdata_q <= bwdata_n;
        end
    end

    assign io.dout      = dout_q;
    assign io.ready     = ready_q;
    assign io.err       = err_q;
    assign io.bus_req   = req_q;
    assign io.bus_we    = bwe_q;
    assign io.bus_addr  = baddr_q;
    assign io.bus_be    = be_q;
    assign io.bus_wdata = bwdata_q;

endmodule
